// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-and-add multiplier responder.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH_DEF = 8;

endpackage

// File: rtl/shift_add_mult_responder_if.sv
// Two-operand / one-result valid-ready interface; master drives operands, slave returns the product.
interface shift_add_mult_responder_if #(
  parameter int WIDTH = mult_pkg::MULT_WIDTH_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   input_1;
  logic [WIDTH-1:0]   input_2;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] output_3;

  modport master (
    output in_valid, input_1, input_2, out_ready,
    input  in_ready, out_valid, output_3
  );

  modport slave (
    input  in_valid, input_1, input_2, out_ready,
    output in_ready, out_valid, output_3
  );

endinterface

// File: rtl/shift_add_mult_responder.sv
// Sequential unsigned multiplier: one operand pair in flight, fixed WIDTH-cycle shift-and-add,
// product held on output_3 until the consumer takes it.
module shift_add_mult_responder
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input logic                       clk,
  input logic                       rst_n,
  shift_add_mult_responder_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mult_state_t   state_q, state_d;
  logic [PW-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] res_q, res_d;

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = {{WIDTH{1'b0}}, bus.input_1};
          b_d     = bus.input_2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        // Always WIDTH iterations, even once B runs out of ones, so latency never varies.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          res_d   = acc_d;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // res_q only loads on the final step, so a partial sum never reaches output_3.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.output_3  = res_q;

endmodule

// File: tb/tb_shift_add_mult_responder.sv
// Randomised self-checking bench for shift_add_mult_responder against a plain-arithmetic product model.
module tb_shift_add_mult_responder;

  localparam int W   = 8;
  localparam int LAT = W;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  shift_add_mult_responder_if #(.WIDTH(W)) bus ();

  shift_add_mult_responder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2*W-1:0] model_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return p[2*W-1:0];
  endfunction

  // One complete transaction: accept, measure latency, optional stall, then the output handshake.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         input bit disturb, input string tag);
    logic [2*W-1:0] exp;
    int lat;
    bit busy_ok;
    bit hold_ok;
    exp = model_mult(a, b);
    bus.input_1  = a;
    bus.input_2  = b;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 30) begin
      if (bus.in_ready) busy_ok = 1'b0;
      if (disturb) begin
        bus.input_1   = W'($urandom);
        bus.input_2   = W'($urandom);
        bus.out_ready = (lat == 3);
      end
      tick();
      lat++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_product"}, 32'(bus.output_3), 32'(exp));
    hold_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.output_3 !== exp) hold_ok = 1'b0;
    end
    if (stall > 0) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_post_keep"}, 32'(bus.output_3), 32'(exp));
  endtask

  initial begin
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   a, b;
    int sent, got, last_acc;
    bit hs_in, hs_out, valid_seen;
    logic [2*W-1:0] obs;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.input_1   = '0;
    bus.input_2   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_output", 32'(bus.output_3), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic case and corners
    run_txn(8'd3, 8'd5, 0, 1'b0, "t1_3x5");
    run_txn(8'd0, 8'd0, 0, 1'b0, "c_0x0");
    run_txn(8'd255, 8'd0, 0, 1'b0, "c_255x0");
    run_txn(8'd0, 8'd255, 0, 1'b0, "c_0x255");
    run_txn(8'd1, 8'd255, 0, 1'b0, "c_1x255");
    run_txn(8'd255, 8'd255, 0, 1'b0, "c_255x255");

    // Backpressure
    run_txn(8'd12, 8'd12, 5, 1'b0, "bp_12x12");

    // Back-to-back with in_valid and out_ready held high
    sent = 0;
    got  = 0;
    last_acc = -1;
    a = W'($urandom);
    b = W'($urandom);
    bus.input_1   = a;
    bus.input_2   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 300 && got < 10; k++) begin
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      obs    = bus.output_3;
      if (hs_out) begin
        if (exp_q.size() > 0) check("b2b_product", 32'(obs), 32'(exp_q.pop_front()));
        else check("b2b_spurious", 32'd1, 32'd0);
        got++;
      end
      tick();
      if (hs_in) begin
        exp_q.push_back(model_mult(a, b));
        if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
        sent++;
        if (sent < 10) begin
          a = W'($urandom);
          b = W'($urandom);
          bus.input_1 = a;
          bus.input_2 = b;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_count", 32'(got), 32'd10);
    tick();

    // Reset in the middle of CALC
    bus.input_1  = 8'd200;
    bus.input_2  = 8'd100;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_output", 32'(bus.output_3), 32'd0);
    valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) valid_seen = 1'b1;
      tick();
    end
    check("mid_rst_no_valid", 32'(valid_seen), 32'd0);
    run_txn(8'd7, 8'd9, 0, 1'b0, "after_rst_7x9");

    // Operand changes and stray out_ready during CALC
    run_txn(8'd6, 8'd7, 0, 1'b1, "disturb_6x7");

    // A few extra random pairs with random stalls
    for (int i = 0; i < 4; i++)
      run_txn(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'b0, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
